// File: rtl/pid_ctrl_mc.sv
// pid_ctrl_mc: multi-channel velocity-form PID controller.
// One shared multiplier, 5-cycle sample period, clamp with anti-windup.
module pid_ctrl_mc #(
   parameter int W    = 16,
   parameter int GW   = 16,
   parameter int FRAC = 8,
   parameter int NCH  = 4,
   parameter int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [GW-1:0] k1,
   input  logic signed [GW-1:0] k2,
   input  logic signed [GW-1:0] k3,
   input  logic signed [W-1:0]  u_max,
   input  logic signed [W-1:0]  u_min,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CW-1:0]        in_ch,
   input  logic                 in_clear,
   input  logic signed [W-1:0]  e_in,
   output logic                 out_valid,
   output logic [CW-1:0]        out_ch,
   output logic signed [W-1:0]  u_out,
   output logic                 sat_hi,
   output logic                 sat_lo
);

   localparam int PW = W + GW;
   localparam int AW = W + GW + 2;
   localparam int SW = W + GW + 3;

   typedef enum logic [2:0] {
      IDLE,
      MAC1,
      MAC2,
      MAC3,
      SAT
   } state_t;

   state_t state;
   state_t state_nx;

   logic signed [W-1:0]  u_prev [NCH];
   logic signed [W-1:0]  e1     [NCH];
   logic signed [W-1:0]  e2     [NCH];

   logic [CW-1:0]        ch_q;
   logic signed [W-1:0]  e_q;
   logic signed [GW-1:0] k1_q;
   logic signed [GW-1:0] k2_q;
   logic signed [GW-1:0] k3_q;
   logic signed [W-1:0]  umax_q;
   logic signed [W-1:0]  umin_q;
   logic signed [AW-1:0] acc;

   logic                 ch_ok;
   logic                 accept;
   logic                 start;
   logic                 clr;
   logic signed [GW-1:0] mul_k;
   logic signed [W-1:0]  mul_e;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] prod_x;
   logic signed [AW-1:0] acc_sh;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] umax_x;
   logic signed [SW-1:0] umin_x;
   logic                 clip_hi;
   logic                 clip_lo;
   logic signed [W-1:0]  u_nx;

   assign ch_ok = 32'(in_ch) < NCH;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // FSM next state: fixed MAC1..SAT walk once a sample is accepted
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = MAC1;
         MAC1:    state_nx = MAC2;
         MAC2:    state_nx = MAC3;
         MAC3:    state_nx = SAT;
         SAT:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs: handshake decode and shared multiplier operand select
   always_comb begin
      in_ready = (state == IDLE) && !reset;
      accept   = in_valid && in_ready;
      start    = accept && !in_clear && ch_ok;
      clr      = accept && in_clear && ch_ok;
      mul_k    = '0;
      mul_e    = '0;
      case (state)
         MAC1: begin
            mul_k = k1_q;
            mul_e = e_q;
         end
         MAC2: begin
            mul_k = k2_q;
            mul_e = e1[ch_q];
         end
         MAC3: begin
            mul_k = k3_q;
            mul_e = e2[ch_q];
         end
         default: begin
            mul_k = '0;
            mul_e = '0;
         end
      endcase
   end

   assign prod   = mul_k * mul_e;
   assign prod_x = {{(AW-PW){prod[PW-1]}}, prod};
   assign acc_sh = acc >>> FRAC;

   // clamp compares at full width so an overflowing sum cannot wrap
   assign sum    = $signed({{(SW-W){u_prev[ch_q][W-1]}}, u_prev[ch_q]})
                 + $signed({acc_sh[AW-1], acc_sh});
   assign umax_x = $signed({{(SW-W){umax_q[W-1]}}, umax_q});
   assign umin_x = $signed({{(SW-W){umin_q[W-1]}}, umin_q});

   // clamp: high limit wins when the limits are inverted
   always_comb begin
      clip_hi = sum > umax_x;
      clip_lo = !clip_hi && (sum < umin_x);
      u_nx    = sum[W-1:0];
      if (clip_hi)
         u_nx = umax_q;
      else if (clip_lo)
         u_nx = umin_q;
   end

   // datapath: snapshot, accumulate, commit clamped result and history
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         u_out     <= '0;
         sat_hi    <= 1'b0;
         sat_lo    <= 1'b0;
         ch_q      <= '0;
         e_q       <= '0;
         k1_q      <= '0;
         k2_q      <= '0;
         k3_q      <= '0;
         umax_q    <= '0;
         umin_q    <= '0;
         acc       <= '0;
         for (int i = 0; i < NCH; i++) begin
            u_prev[i] <= '0;
            e1[i]     <= '0;
            e2[i]     <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         if (start) begin
            ch_q   <= in_ch;
            e_q    <= e_in;
            k1_q   <= k1;
            k2_q   <= k2;
            k3_q   <= k3;
            umax_q <= u_max;
            umin_q <= u_min;
         end
         if (clr) begin
            u_prev[in_ch] <= '0;
            e1[in_ch]     <= '0;
            e2[in_ch]     <= '0;
         end
         case (state)
            MAC1: acc <= prod_x;
            MAC2: acc <= acc - prod_x;
            MAC3: acc <= acc + prod_x;
            SAT: begin
               out_valid    <= 1'b1;
               out_ch       <= ch_q;
               u_out        <= u_nx;
               sat_hi       <= clip_hi;
               sat_lo       <= clip_lo;
               u_prev[ch_q] <= u_nx;
               e1[ch_q]     <= e_q;
               e2[ch_q]     <= e1[ch_q];
            end
            default: acc <= acc;
         endcase
      end
   end

endmodule

// File: tb/tb_pid_ctrl_mc.sv
// tb_pid_ctrl_mc: directed vector bench for pid_ctrl_mc.
// Five channels so that in_ch = NCH is representable.
module tb_pid_ctrl_mc;

   localparam int W    = 16;
   localparam int GW   = 16;
   localparam int FRAC = 8;
   localparam int NCH  = 5;
   localparam int CW   = 3;

   logic                 clk = 1'b0;
   logic                 reset;
   logic signed [GW-1:0] k1, k2, k3;
   logic signed [W-1:0]  u_max, u_min;
   logic                 in_valid;
   logic                 in_ready;
   logic [CW-1:0]        in_ch;
   logic                 in_clear;
   logic signed [W-1:0]  e_in;
   logic                 out_valid;
   logic [CW-1:0]        out_ch;
   logic signed [W-1:0]  u_out;
   logic                 sat_hi, sat_lo;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int ch;
      int e;
      int k1;
      int k2;
      int k3;
      int umax;
      int umin;
      int u;
      int hi;
      int lo;
   } vec_t;

   vec_t tbl[16];

   pid_ctrl_mc #(
      .W(W), .GW(GW), .FRAC(FRAC), .NCH(NCH), .CW(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .k1(k1),
      .k2(k2),
      .k3(k3),
      .u_max(u_max),
      .u_min(u_min),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_ch(in_ch),
      .in_clear(in_clear),
      .e_in(e_in),
      .out_valid(out_valid),
      .out_ch(out_ch),
      .u_out(u_out),
      .sat_hi(sat_hi),
      .sat_lo(sat_lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Handshake one request, then scramble gains/limits to prove snapshotting.
   task automatic send(input int ch, input bit clr, input int e,
                       input int g1, input int g2, input int g3,
                       input int hi, input int lo);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) check("ready_wait", 0, 1);
      in_ch    = CW'(ch);
      in_clear = clr;
      e_in     = W'(e);
      k1       = GW'(g1);
      k2       = GW'(g2);
      k3       = GW'(g3);
      u_max    = W'(hi);
      u_min    = W'(lo);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_clear = 1'b0;
      e_in     = W'($urandom);
      k1       = GW'($urandom);
      k2       = GW'($urandom);
      k3       = GW'($urandom);
      u_max    = W'($urandom);
      u_min    = W'($urandom);
   endtask

   task automatic expect_result(input string name, input int ch, input int u,
                                input int hi, input int lo);
      int lat = 0;
      bit seen = 1'b0;
      for (int i = 1; i <= 10 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      check({name, ".latency"}, lat, 4);
      if (seen) begin
         check({name, ".u_out"}, u_out, u);
         check({name, ".out_ch"}, out_ch, ch);
         check({name, ".sat_hi"}, sat_hi, hi);
         check({name, ".sat_lo"}, sat_lo, lo);
         @(posedge clk);
         #1;
         check({name, ".pulse"}, out_valid, 0);
         check({name, ".hold"}, u_out, u);
      end
   endtask

   task automatic expect_none(input string name, input int cycles);
      bit seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check(name, seen, 0);
   endtask

   initial begin
      // proportional pass-through, ch0
      tbl[0]  = '{0, 100, 256, 0, 0, 32767, -32767, 100, 0, 0};
      tbl[1]  = '{0, 50, 256, 0, 0, 32767, -32767, 150, 0, 0};
      // full PID history, ch1: acc 5120, 7680, -3840
      tbl[2]  = '{1, 10, 512, 256, 128, 32767, -32767, 20, 0, 0};
      tbl[3]  = '{1, 20, 512, 256, 128, 32767, -32767, 50, 0, 0};
      tbl[4]  = '{1, 0, 512, 256, 128, 32767, -32767, 35, 0, 0};
      // saturation and anti-windup, ch2
      tbl[5]  = '{2, 150, 256, 0, 0, 200, -32767, 150, 0, 0};
      tbl[6]  = '{2, 150, 256, 0, 0, 200, -32767, 200, 1, 0};
      tbl[7]  = '{2, -10, 256, 0, 0, 200, -32767, 190, 0, 0};
      // truncation toward -inf, ch3
      tbl[8]  = '{3, -3, 128, 0, 0, 32767, -32767, -2, 0, 0};
      tbl[9]  = '{3, -1, 128, 0, 0, 32767, -32767, -3, 0, 0};
      // same stimulus with u_min = -2, ch4
      tbl[10] = '{4, -3, 128, 0, 0, 32767, -2, -2, 0, 0};
      tbl[11] = '{4, -1, 128, 0, 0, 32767, -2, -2, 0, 1};
      // interleaved channels keep independent u_prev
      tbl[12] = '{0, 10, 256, 0, 0, 32767, -32767, 160, 0, 0};
      tbl[13] = '{1, 5, 256, 0, 0, 32767, -32767, 40, 0, 0};
      tbl[14] = '{0, -20, 256, 0, 0, 32767, -32767, 140, 0, 0};
      tbl[15] = '{1, 0, 256, 0, 0, 32767, -32767, 40, 0, 0};

      reset    = 1'b1;
      in_valid = 1'b0;
      in_clear = 1'b0;
      in_ch    = '0;
      e_in     = '0;
      k1       = '0;
      k2       = '0;
      k3       = '0;
      u_max    = '0;
      u_min    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.in_ready", in_ready, 0);
      check("rst.out_valid", out_valid, 0);
      check("rst.u_out", u_out, 0);
      check("rst.out_ch", out_ch, 0);
      check("rst.sat_hi", sat_hi, 0);
      check("rst.sat_lo", sat_lo, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rst.ready_after", in_ready, 1);

      for (int i = 0; i < 16; i++) begin
         send(tbl[i].ch, 1'b0, tbl[i].e, tbl[i].k1, tbl[i].k2, tbl[i].k3,
              tbl[i].umax, tbl[i].umin);
         expect_result($sformatf("vec%0d", i), tbl[i].ch, tbl[i].u,
                       tbl[i].hi, tbl[i].lo);
      end

      // clear ch0 (u_prev was 140): one cycle, no result, ready stays high
      send(0, 1'b1, 0, 0, 0, 0, 0, 0);
      check("clear.ready", in_ready, 1);
      expect_none("clear.no_out", 8);
      send(0, 1'b0, 100, 256, 0, 0, 32767, -32767);
      expect_result("clear.after", 0, 100, 0, 0);

      // out-of-range channel is dropped
      send(NCH, 1'b0, 100, 256, 0, 0, 32767, -32767);
      check("badch.ready", in_ready, 1);
      expect_none("badch.no_out", 8);

      // reset one cycle into a computation on ch2 (u_prev 190)
      send(2, 1'b0, 100, 256, 0, 0, 32767, -32767);
      begin
         bit seen = 1'b0;
         if (out_valid) seen = 1'b1;
         @(posedge clk);
         #1;
         reset = 1'b1;
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
         check("midrst.ready_low", in_ready, 0);
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
         reset = 1'b0;
         #1;
         check("midrst.ready_high", in_ready, 1);
         check("midrst.no_out_in_rst", seen, 0);
      end
      expect_none("midrst.no_out", 8);
      send(2, 1'b0, 100, 256, 0, 0, 32767, -32767);
      expect_result("midrst.after", 2, 100, 0, 0);

      // inverted limits: high-limit test wins
      send(3, 1'b0, 100, 256, 0, 0, -5, 5);
      expect_result("inverted", 3, -5, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
